// File: rtl/mmio_interconnect_pkg.sv
// rtl/mmio_interconnect_pkg.sv - shared types and constants for the MMIO interconnect
package mmio_interconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mmio_state_e;

  localparam logic [1:0] MMIO_AREA = 2'h3;

  localparam logic [5:0] PREFIX_TRNG        = 6'h00;
  localparam logic [5:0] PREFIX_TIMER       = 6'h01;
  localparam logic [5:0] PREFIX_UDS         = 6'h02;
  localparam logic [5:0] PREFIX_UART        = 6'h03;
  localparam logic [5:0] PREFIX_TOUCH_SENSE = 6'h04;
  localparam logic [5:0] PREFIX_MTA1        = 6'h3f;

  // Core i lives at bits [i*6 +: 6], so the last element is core 0.
  localparam logic [47:0] DEFAULT_CORE_PREFIXES = {
    PREFIX_MTA1, 6'h05, PREFIX_TOUCH_SENSE, PREFIX_UART,
    PREFIX_UDS, PREFIX_TIMER, PREFIX_TRNG, 6'h06
  };

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hdeadbeef;

endpackage

// File: rtl/mmio_prefix_decode.sv
// rtl/mmio_prefix_decode.sv - combinational prefix table lookup, lowest matching index wins
module mmio_prefix_decode #(
  parameter int NUM_CORES = 8,
  parameter int PREFIX_W  = 6,
  parameter int SEL_W     = 3,
  parameter logic [NUM_CORES*PREFIX_W-1:0] CORE_PREFIXES = '0
) (
  input  logic [PREFIX_W-1:0] prefix,
  output logic                hit,
  output logic [SEL_W-1:0]    sel
);

  // Scan from the top down so a lower index overwrites any higher match.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (CORE_PREFIXES[i*PREFIX_W +: PREFIX_W] == prefix) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// rtl/mmio_interconnect.sv - CPU valid/ready to per-core MMIO decode, access FSM, timeout and error log
module mmio_interconnect
  import mmio_interconnect_pkg::*;
#(
  parameter int NUM_CORES      = 8,
  parameter int PREFIX_W       = 6,
  parameter logic [NUM_CORES*PREFIX_W-1:0] CORE_PREFIXES = DEFAULT_CORE_PREFIXES,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_valid,
  input  logic [31:0]             cpu_addr,
  input  logic [3:0]              cpu_wstrb,
  input  logic [31:0]             cpu_wdata,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_ready,
  output logic [NUM_CORES-1:0]    core_cs,
  output logic                    core_we,
  output logic [ADDR_W-1:0]       core_address,
  output logic [31:0]             core_write_data,
  input  logic [NUM_CORES*32-1:0] core_read_data,
  input  logic [NUM_CORES-1:0]    core_ready,
  input  logic                    err_clear,
  output logic                    err_valid,
  output logic [31:0]             err_addr,
  output logic [15:0]             err_count
);

  localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  mmio_state_e       state;
  logic [SEL_W-1:0]  sel_q;
  logic [TMO_W-1:0]  tmo;
  logic [31:0]       req_addr;
  logic              resp_gap;
  logic [15:0]       err_count_q;
  logic [31:0]       err_addr_q;

  logic              dec_hit;
  logic [SEL_W-1:0]  dec_sel;
  logic              accept;
  logic              sel_ready;
  logic [31:0]       sel_rdata;
  logic              fault;
  logic [31:0]       fault_addr;

  mmio_prefix_decode #(
    .NUM_CORES     (NUM_CORES),
    .PREFIX_W      (PREFIX_W),
    .SEL_W         (SEL_W),
    .CORE_PREFIXES (CORE_PREFIXES)
  ) u_decode (
    .prefix (cpu_addr[24 +: PREFIX_W]),
    .hit    (dec_hit),
    .sel    (dec_sel)
  );

  // Request acceptance, selected-core response and fault detection for this cycle.
  always_comb begin
    accept     = (state == ST_IDLE) && cpu_valid && !resp_gap;
    sel_ready  = core_ready[sel_q];
    sel_rdata  = core_read_data[32*int'(sel_q) +: 32];
    fault      = 1'b0;
    fault_addr = req_addr;
    if (accept && !dec_hit) begin
      fault      = 1'b1;
      fault_addr = cpu_addr;
    end else if ((state == ST_ACCESS) && !sel_ready && (tmo == TMO_LAST)) begin
      fault = 1'b1;
    end
  end

  // Access FSM: latch request on accept, hold cs until ready or timeout, then pulse cpu_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      sel_q           <= '0;
      tmo             <= '0;
      req_addr        <= '0;
      resp_gap        <= 1'b0;
      cpu_ready       <= 1'b0;
      cpu_rdata       <= '0;
      core_cs         <= '0;
      core_we         <= 1'b0;
      core_address    <= '0;
      core_write_data <= '0;
      err_valid       <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      err_valid <= fault;
      case (state)
        ST_IDLE: begin
          resp_gap <= 1'b0;
          if (accept) begin
            req_addr        <= cpu_addr;
            core_address    <= cpu_addr[ADDR_W+1:2];
            core_we         <= |cpu_wstrb;
            core_write_data <= cpu_wdata;
            if (dec_hit) begin
              sel_q   <= dec_sel;
              core_cs <= NUM_CORES'(1) << dec_sel;
              tmo     <= '0;
              state   <= ST_ACCESS;
            end else begin
              cpu_rdata <= ERR_RDATA;
              cpu_ready <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            cpu_rdata <= sel_rdata;
            cpu_ready <= 1'b1;
            core_cs   <= '0;
            state     <= ST_RESP;
          end else if (tmo == TMO_LAST) begin
            cpu_rdata <= ERR_RDATA;
            cpu_ready <= 1'b1;
            core_cs   <= '0;
            state     <= ST_RESP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ST_RESP: begin
          resp_gap <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          core_cs <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Error log: a clear coinciding with a fault leaves exactly that fault recorded.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else if (fault) begin
      err_addr_q <= fault_addr;
      if (err_clear) begin
        err_count_q <= 16'd1;
      end else if (err_count_q != 16'hffff) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end else if (err_clear) begin
      err_count_q <= '0;
      err_addr_q  <= '0;
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// tb/tb_mmio_interconnect.sv - self-checking bench for mmio_interconnect
module tb_mmio_interconnect;

  localparam int NC = 8;
  localparam int T  = 16;
  localparam logic [31:0] ERR = 32'hdeadbeef;

  logic             clk = 1'b0;
  logic             reset;
  logic             cpu_valid;
  logic [31:0]      cpu_addr;
  logic [3:0]       cpu_wstrb;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             cpu_ready;
  logic [NC-1:0]    core_cs;
  logic             core_we;
  logic [7:0]       core_address;
  logic [31:0]      core_write_data;
  logic [NC*32-1:0] core_read_data;
  logic [NC-1:0]    core_ready;
  logic             err_clear;
  logic             err_valid;
  logic [31:0]      err_addr;
  logic [15:0]      err_count;

  int checks = 0;
  int failures = 0;

  // Prefix owned by each core index, as given by the default flattened table.
  logic [5:0]  prefix_tab [NC] = '{6'h06, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h3f};
  logic [31:0] core_data [NC];
  int          rsp_delay = 0;
  int          cs_age = 0;
  logic [15:0] m_cnt = 16'h0;
  logic [31:0] m_addr = 32'h0;

  always #5 clk = ~clk;

  mmio_interconnect dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_valid       (cpu_valid),
    .cpu_addr        (cpu_addr),
    .cpu_wstrb       (cpu_wstrb),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_ready       (cpu_ready),
    .core_cs         (core_cs),
    .core_we         (core_we),
    .core_address    (core_address),
    .core_write_data (core_write_data),
    .core_read_data  (core_read_data),
    .core_ready      (core_ready),
    .err_clear       (err_clear),
    .err_valid       (err_valid),
    .err_addr        (err_addr),
    .err_count       (err_count)
  );

  // Core behaviour: answer after rsp_delay cycles of chip select.
  always @(posedge clk) cs_age <= (core_cs != '0) ? cs_age + 1 : 0;
  assign core_ready = (cs_age == rsp_delay) ? core_cs : '0;

  always_comb begin
    core_read_data = '0;
    for (int i = 0; i < NC; i++) core_read_data[i*32 +: 32] = core_data[i];
  end

  function automatic int lookup(input logic [5:0] p);
    for (int i = 0; i < NC; i++) if (prefix_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_ready"}, 32'(cpu_ready), 32'h0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    chk({tag, "_core_cs"}, 32'(core_cs), 32'h0);
    chk({tag, "_core_we"}, 32'(core_we), 32'h0);
    chk({tag, "_core_address"}, 32'(core_address), 32'h0);
    chk({tag, "_core_wdata"}, core_write_data, 32'h0);
    chk({tag, "_err_valid"}, 32'(err_valid), 32'h0);
    chk({tag, "_err_addr"}, err_addr, 32'h0);
    chk({tag, "_err_count"}, 32'(err_count), 32'h0);
  endtask

  // One CPU access from a clean IDLE cycle; ends in a clean IDLE cycle.
  task automatic access(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                        input int dly, input logic clr, input logic hold);
    int exp_core, exp_lat, exp_cs, cs_seen;
    logic exp_fault, done;
    logic [31:0] exp_rd;
    exp_core = lookup(a[29:24]);
    if (exp_core < 0) begin
      exp_lat = 1; exp_cs = 0; exp_fault = 1'b1; exp_rd = ERR;
    end else if (dly >= T) begin
      exp_lat = T + 1; exp_cs = T; exp_fault = 1'b1; exp_rd = ERR;
    end else begin
      exp_lat = dly + 2; exp_cs = dly + 1; exp_fault = 1'b0; exp_rd = core_data[exp_core];
    end
    if (clr) begin m_cnt = 16'h0; m_addr = 32'h0; end
    if (exp_fault) begin
      if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'h1;
      m_addr = a;
    end
    rsp_delay = dly;
    cpu_valid = 1'b1; cpu_addr = a; cpu_wstrb = ws; cpu_wdata = wd; err_clear = clr;
    cs_seen = 0;
    done = 1'b0;
    for (int k = 1; k <= 64 && !done; k++) begin
      @(negedge clk);
      err_clear = 1'b0;
      if (core_cs != '0) begin
        if (cs_seen == 0) begin
          chk("cs_onehot", 32'(core_cs), (exp_core >= 0) ? (32'h1 << exp_core) : 32'h0);
          chk("core_address", 32'(core_address), 32'(a[9:2]));
          chk("core_we", 32'(core_we), 32'(ws != 4'h0));
          chk("core_wdata", core_write_data, wd);
        end
        cs_seen++;
      end
      if (cpu_ready) begin
        done = 1'b1;
        chk("latency", 32'(k), 32'(exp_lat));
        chk("cpu_rdata", cpu_rdata, exp_rd);
        chk("err_valid", 32'(err_valid), 32'(exp_fault));
        chk("cs_cycles", 32'(cs_seen), 32'(exp_cs));
        chk("err_count", 32'(err_count), 32'(m_cnt));
        chk("err_addr", err_addr, m_addr);
        if (!hold) cpu_valid = 1'b0;
      end else if (err_valid) begin
        chk("err_valid_early", 32'(err_valid), 32'h0);
      end
    end
    chk("resp_seen", 32'(done), 32'h1);
    @(negedge clk);
    chk("gap_cs", 32'(core_cs), 32'h0);
    chk("gap_ready", 32'(cpu_ready), 32'h0);
    if (hold) begin
      @(posedge clk);
      #1 cpu_valid = 1'b0;
      @(negedge clk);
      chk("hold_cs", 32'(core_cs), 32'h0);
      chk("hold_ready", 32'(cpu_ready), 32'h0);
    end else begin
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] core_addr(input int c, input logic [23:0] off);
    return {2'b11, prefix_tab[c], off};
  endfunction

  initial begin
    logic [31:0] a;
    int c, d;
    reset = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_wstrb = '0; cpu_wdata = '0; err_clear = 1'b0;
    for (int i = 0; i < NC; i++) core_data[i] = $urandom;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Read from prefix 6'h01, core answers in its first cs cycle.
    core_data[lookup(6'h01)] = 32'h12345678;
    access(32'hc1000008, 4'h0, 32'h0, 0, 1'b0, 1'b0);

    // Write: core drives no read data, so cpu_rdata is 0.
    core_data[lookup(6'h03)] = 32'h0;
    access(32'hc3000010, 4'hf, 32'hcafef00d, 0, 1'b0, 1'b0);

    // Unmapped prefix.
    access(32'hc7000000, 4'h0, 32'h0, 0, 1'b0, 1'b0);

    // Timeout boundaries on core 2: never ready, ready on 16th cycle, ready one too late.
    core_data[2] = 32'h0badf00d;
    access(core_addr(2, 24'h000020), 4'h0, 32'h0, 255, 1'b0, 1'b0);
    access(core_addr(2, 24'h000024), 4'h0, 32'h0, T - 1, 1'b0, 1'b0);
    access(core_addr(2, 24'h000028), 4'h0, 32'h0, T, 1'b0, 1'b0);

    // CPU keeps valid high past the response: no second accept.
    access(core_addr(5, 24'h000100), 4'h3, 32'h11223344, 2, 1'b0, 1'b1);
    access(32'hc8000004, 4'h0, 32'h0, 0, 1'b0, 1'b1);

    // Saturation from 16'hfffe.
    force dut.err_count_q = 16'hfffe;
    @(negedge clk);
    release dut.err_count_q;
    @(negedge clk);
    m_cnt = 16'hfffe;
    chk("forced_count", 32'(err_count), 32'h0000fffe);
    for (int i = 0; i < 3; i++) access(32'hc9000000 + 32'(i * 4), 4'h0, 32'h0, 0, 1'b0, 1'b0);

    // Clear coincident with a fault, then a clear alone on a hit.
    access(32'hca000040, 4'h0, 32'h0, 0, 1'b1, 1'b0);
    access(core_addr(0, 24'h000008), 4'h0, 32'h0, 1, 1'b1, 1'b0);

    // Reset in the 3rd ACCESS cycle.
    rsp_delay = 255;
    cpu_valid = 1'b1; cpu_addr = core_addr(4, 24'h000010); cpu_wstrb = 4'h5; cpu_wdata = 32'h55aa55aa;
    repeat (3) @(negedge clk);
    chk("pre_reset_cs", 32'(core_cs), 32'h1 << 4);
    reset = 1'b1; cpu_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    m_cnt = 16'h0; m_addr = 32'h0;
    @(negedge clk);
    chk("post_reset_cs", 32'(core_cs), 32'h0);
    core_data[1] = 32'h87654321;
    access(core_addr(1, 24'h0000fc), 4'h0, 32'h0, 0, 1'b0, 1'b0);

    // Randomized accesses against the model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NC; i++) core_data[i] = $urandom;
      c = int'($urandom_range(0, NC - 1));
      a = {2'b11, ($urandom_range(0, 1) == 1) ? prefix_tab[c] : 6'($urandom), 24'($urandom)};
      case ($urandom_range(0, 7))
        0: d = T - 1;
        1: d = T;
        default: d = int'($urandom_range(0, 3));
      endcase
      access(a, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
             $urandom, d, ($urandom_range(0, 9) == 0), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
